// File: rtl/slow_vram_sdram_bridge.sv
// Slow VRAM (32K x 16) backed by SDRAM: one-entry word-pair holding register,
// 1-deep write queue and a req/ack sequencer toward the SDRAM controller.
module slow_vram_sdram_bridge #(
  parameter int                  SDRAM_AW  = 24,
  parameter logic [SDRAM_AW-1:0] VRAM_BASE = 24'h0F0000
) (
  input  logic                CLK,
  input  logic                RESETP,
  input  logic [14:0]         SVRAM_ADDR,
  input  logic [15:0]         SVRAM_DATA_OUT,
  input  logic                BWE,
  input  logic                BOE,
  input  logic [1:0]          VRAM_CYCLE,
  output logic [31:0]         SVRAM_DATA_IN,
  output logic                SDRAM_REQ,
  output logic                SDRAM_WE,
  output logic [SDRAM_AW-1:0] SDRAM_ADDR,
  output logic [15:0]         SDRAM_DIN,
  input  logic                SDRAM_ACK,
  input  logic [31:0]         SDRAM_DOUT,
  output logic                WR_OVF,
  output logic [1:0]          DBG_STATE
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WR_REQ = 2'd1;
  localparam logic [1:0] S_RD_REQ = 2'd2;

  // Valid/ready: SDRAM_REQ rises with WE/ADDR/DIN valid and all four hold
  // steady until the one-cycle SDRAM_ACK; REQ falls on the edge that sees ACK.

  logic [1:0]          state_q, state_d;
  logic                req_q, req_d;
  logic                we_q, we_d;
  logic [SDRAM_AW-1:0] addr_q, addr_d;
  logic [15:0]         din_q, din_d;
  logic [31:0]         hold_q, hold_d;
  logic [13:0]         tag_q, tag_d;
  logic                valid_q, valid_d;
  logic [13:0]         pend_q, pend_d;
  logic                bwe_q;
  logic                wq_valid_q, wq_valid_d;
  logic [14:0]         wq_addr_q, wq_addr_d;
  logic [15:0]         wq_data_q, wq_data_d;
  logic                ovf_q, ovf_d;

  logic wr_edge;
  logic hit;
  logic [31:0] filled;

  wire unused_boe = BOE;

  function automatic logic [31:0] merge_word(input logic [31:0] w, input logic hi,
                                             input logic [15:0] d);
    merge_word = hi ? {d, w[15:0]} : {w[31:16], d};
  endfunction

  assign wr_edge = bwe_q & ~BWE;
  assign hit     = valid_q && (tag_q == SVRAM_ADDR[14:1]);

  assign SVRAM_DATA_IN = {hold_q[31:16], SVRAM_ADDR[0] ? hold_q[31:16] : hold_q[15:0]};
  assign SDRAM_REQ     = req_q;
  assign SDRAM_WE      = we_q;
  assign SDRAM_ADDR    = addr_q;
  assign SDRAM_DIN     = din_q;
  assign WR_OVF        = ovf_q;
  assign DBG_STATE     = state_q;

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    din_d      = din_q;
    hold_d     = hold_q;
    tag_d      = tag_q;
    valid_d    = valid_q;
    pend_d     = pend_q;
    wq_valid_d = wq_valid_q;
    wq_addr_d  = wq_addr_q;
    wq_data_d  = wq_data_q;
    ovf_d      = ovf_q;
    filled     = SDRAM_DOUT;

    if (wr_edge) begin
      if (wq_valid_q) begin
        ovf_d = 1'b1;
      end else begin
        wq_valid_d = 1'b1;
        wq_addr_d  = SVRAM_ADDR;
        wq_data_d  = SVRAM_DATA_OUT;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (wq_valid_q) begin
          we_d    = 1'b1;
          addr_d  = VRAM_BASE + {{(SDRAM_AW-15){1'b0}}, wq_addr_q};
          din_d   = wq_data_q;
          req_d   = 1'b1;
          state_d = S_WR_REQ;
          if (valid_q && (tag_q == wq_addr_q[14:1]))
            hold_d = merge_word(hold_q, wq_addr_q[0], wq_data_q);
        // A write edge arriving now is queued first, so the read waits for it.
        end else if (!wr_edge && !hit && (VRAM_CYCLE != 2'b11)) begin
          we_d    = 1'b0;
          addr_d  = VRAM_BASE + {{(SDRAM_AW-15){1'b0}}, SVRAM_ADDR[14:1], 1'b0};
          pend_d  = SVRAM_ADDR[14:1];
          req_d   = 1'b1;
          state_d = S_RD_REQ;
        end
      end
      S_WR_REQ: begin
        if (SDRAM_ACK) begin
          req_d      = 1'b0;
          wq_valid_d = 1'b0;
          state_d    = S_IDLE;
        end
      end
      S_RD_REQ: begin
        if (SDRAM_ACK) begin
          // Keep the fill coherent with a write queued while the read was in flight.
          if (wq_valid_q && (wq_addr_q[14:1] == pend_q))
            filled = merge_word(SDRAM_DOUT, wq_addr_q[0], wq_data_q);
          hold_d  = filled;
          tag_d   = pend_q;
          valid_d = 1'b1;
          req_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESETP) begin
    if (!RESETP) begin
      state_q    <= S_IDLE;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      din_q      <= '0;
      hold_q     <= '0;
      tag_q      <= '0;
      valid_q    <= 1'b0;
      pend_q     <= '0;
      bwe_q      <= 1'b1;
      wq_valid_q <= 1'b0;
      wq_addr_q  <= '0;
      wq_data_q  <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      hold_q     <= hold_d;
      tag_q      <= tag_d;
      valid_q    <= valid_d;
      pend_q     <= pend_d;
      bwe_q      <= BWE;
      wq_valid_q <= wq_valid_d;
      wq_addr_q  <= wq_addr_d;
      wq_data_q  <= wq_data_d;
      ovf_q      <= ovf_d;
    end
  end

endmodule

// File: tb/tb_slow_vram_sdram_bridge.sv
// Directed bench for slow_vram_sdram_bridge: SDRAM requests are checked
// against an expected queue; holding-register data and flags are checked directly.
module tb_slow_vram_sdram_bridge;

  logic        CLK;
  logic        RESETP;
  logic [14:0] SVRAM_ADDR;
  logic [15:0] SVRAM_DATA_OUT;
  logic        BWE;
  logic        BOE;
  logic [1:0]  VRAM_CYCLE;
  logic [31:0] SVRAM_DATA_IN;
  logic        SDRAM_REQ;
  logic        SDRAM_WE;
  logic [23:0] SDRAM_ADDR;
  logic [15:0] SDRAM_DIN;
  logic        SDRAM_ACK;
  logic [31:0] SDRAM_DOUT;
  logic        WR_OVF;
  logic [1:0]  DBG_STATE;

  int vectors = 0;
  int miscompares = 0;

  // Entry: {check_din, we, addr[23:0], din[15:0]}
  logic [41:0] exp_q[$];

  slow_vram_sdram_bridge dut (
    .CLK(CLK), .RESETP(RESETP), .SVRAM_ADDR(SVRAM_ADDR), .SVRAM_DATA_OUT(SVRAM_DATA_OUT),
    .BWE(BWE), .BOE(BOE), .VRAM_CYCLE(VRAM_CYCLE), .SVRAM_DATA_IN(SVRAM_DATA_IN),
    .SDRAM_REQ(SDRAM_REQ), .SDRAM_WE(SDRAM_WE), .SDRAM_ADDR(SDRAM_ADDR), .SDRAM_DIN(SDRAM_DIN),
    .SDRAM_ACK(SDRAM_ACK), .SDRAM_DOUT(SDRAM_DOUT), .WR_OVF(WR_OVF), .DBG_STATE(DBG_STATE)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic push_rd(input logic [23:0] a);
    exp_q.push_back({1'b0, 1'b0, a, 16'h0000});
  endtask

  task automatic push_wr(input logic [23:0] a, input logic [15:0] d);
    exp_q.push_back({1'b1, 1'b1, a, d});
  endtask

  // Wait (bounded) for REQ, then pop the expected request and compare.
  task automatic wait_req(input string tag);
    int n;
    logic [41:0] e;
    logic [41:0] o;
    n = 0;
    while (SDRAM_REQ !== 1'b1 && n < 20) begin
      @(negedge CLK);
      n++;
    end
    if (SDRAM_REQ !== 1'b1) begin
      chk({tag, "_timeout"}, {63'd0, SDRAM_REQ}, 64'd1);
    end else if (exp_q.size() == 0) begin
      chk({tag, "_unexpected"}, 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      o = {e[41], SDRAM_WE, SDRAM_ADDR, e[41] ? SDRAM_DIN : 16'h0000};
      chk(tag, {22'd0, o}, {22'd0, e});
    end
  endtask

  task automatic ack(input logic [31:0] d);
    @(posedge CLK);
    #1;
    SDRAM_ACK  = 1'b1;
    SDRAM_DOUT = d;
    @(posedge CLK);
    #1;
    SDRAM_ACK = 1'b0;
    @(negedge CLK);
  endtask

  task automatic chk_no_req(input string tag, input int cycles);
    int highs;
    highs = 0;
    repeat (cycles) begin
      @(negedge CLK);
      if (SDRAM_REQ !== 1'b0) highs++;
    end
    chk(tag, 64'(highs), 64'd0);
  endtask

  initial begin
    RESETP = 1'b0; SVRAM_ADDR = '0; SVRAM_DATA_OUT = '0; BWE = 1'b1; BOE = 1'b1;
    VRAM_CYCLE = 2'b11; SDRAM_ACK = 1'b0; SDRAM_DOUT = '0;
    step(3);
    @(negedge CLK);
    chk("rst_data_in", 64'(SVRAM_DATA_IN), 64'd0);
    chk("rst_req_we", {62'd0, SDRAM_REQ, SDRAM_WE}, 64'd0);
    chk("rst_addr_din", {24'd0, SDRAM_ADDR, SDRAM_DIN}, 64'd0);
    chk("rst_ovf", {63'd0, WR_OVF}, 64'd0);
    RESETP = 1'b1;
    step(2);

    // First miss: REQ one clock later, fill shown the clock after ACK
    SVRAM_ADDR = 15'h7000; VRAM_CYCLE = 2'b00;
    push_rd(24'h0F7000);
    @(negedge CLK);
    chk("miss_not_yet", {63'd0, SDRAM_REQ}, 64'd0);
    @(negedge CLK);
    chk("miss_latency", {63'd0, SDRAM_REQ}, 64'd1);
    wait_req("rd_7000");
    ack(32'h12345678);
    chk("fill_7000", 64'(SVRAM_DATA_IN), 64'h12345678);
    chk("req_drop", {63'd0, SDRAM_REQ}, 64'd0);

    // Odd word of the same pair hits
    step(1);
    SVRAM_ADDR = 15'h7001;
    chk_no_req("hit_7001_noreq", 4);
    chk("hit_7001_data", 64'(SVRAM_DATA_IN), 64'h12341234);

    // Write to a held pair merges and issues a write
    step(1);
    SVRAM_ADDR = 15'h7000; SVRAM_DATA_OUT = 16'hBEEF; BWE = 1'b0;
    step(1);
    BWE = 1'b1;
    push_wr(24'h0F7000, 16'hBEEF);
    wait_req("wr_7000");
    chk("merge_7000", 64'(SVRAM_DATA_IN), 64'h1234BEEF);
    ack(32'h0);
    chk("wr_ack_drop", {63'd0, SDRAM_REQ}, 64'd0);

    // Write edge while a read to the same pair is in flight
    step(1);
    SVRAM_ADDR = 15'h0100;
    push_rd(24'h0F0100);
    wait_req("rd_0100");
    step(1);
    SVRAM_ADDR = 15'h0101; SVRAM_DATA_OUT = 16'hCAFE; BWE = 1'b0;
    step(1);
    BWE = 1'b1; SVRAM_ADDR = 15'h0100;
    ack(32'h11112222);
    chk("coherent_fill", 64'(SVRAM_DATA_IN), 64'hCAFE2222);
    push_wr(24'h0F0101, 16'hCAFE);
    wait_req("wr_0101");
    ack(32'h0);
    chk("no_ovf_yet", {63'd0, WR_OVF}, 64'd0);

    // Second write edge before the first write's ACK is dropped
    step(1);
    SVRAM_DATA_OUT = 16'h1111; BWE = 1'b0;
    step(1);
    BWE = 1'b1;
    step(1);
    SVRAM_DATA_OUT = 16'h2222; BWE = 1'b0;
    step(1);
    BWE = 1'b1;
    push_wr(24'h0F0100, 16'h1111);
    wait_req("wr_0100_first");
    @(negedge CLK);
    chk("ovf_set", {63'd0, WR_OVF}, 64'd1);
    ack(32'h0);
    chk_no_req("dropped_write", 4);
    chk("merge_0100", 64'(SVRAM_DATA_IN), 64'hCAFE1111);

    // Simultaneous write edge and read miss: write goes first
    step(1);
    SVRAM_ADDR = 15'h2000; SVRAM_DATA_OUT = 16'h5555; BWE = 1'b0;
    step(1);
    BWE = 1'b1;
    push_wr(24'h0F2000, 16'h5555);
    push_rd(24'h0F2000);
    wait_req("wr_2000_first");
    ack(32'h0);
    wait_req("rd_2000_after");
    ack(32'h99995555);
    chk("fill_2000", 64'(SVRAM_DATA_IN), 64'h99995555);
    chk("ovf_sticky", {63'd0, WR_OVF}, 64'd1);

    // Idle slot suppresses the fill; old pair shown on miss
    step(1);
    VRAM_CYCLE = 2'b11; SVRAM_ADDR = 15'h3000;
    chk_no_req("idle_slot_noreq", 4);
    chk("miss_shows_old", 64'(SVRAM_DATA_IN), 64'h99995555);
    step(1);
    VRAM_CYCLE = 2'b00;
    push_rd(24'h0F3000);
    wait_req("rd_3000");

    // Reset mid-request, then a stray ACK
    VRAM_CYCLE = 2'b11;
    RESETP = 1'b0;
    #1;
    chk("rst_drops_req", {63'd0, SDRAM_REQ}, 64'd0);
    chk("rst_clears_ovf", {63'd0, WR_OVF}, 64'd0);
    step(2);
    RESETP = 1'b1;
    step(1);
    SDRAM_ACK = 1'b1; SDRAM_DOUT = 32'hDEADBEEF;
    step(1);
    SDRAM_ACK = 1'b0;
    @(negedge CLK);
    chk("stray_ack_data", 64'(SVRAM_DATA_IN), 64'd0);
    chk("stray_ack_state", {62'd0, DBG_STATE}, 64'd0);
    chk("stray_ack_req", {63'd0, SDRAM_REQ}, 64'd0);

    // Holding register invalidated by reset: address 0 misses
    step(1);
    SVRAM_ADDR = 15'h0000; VRAM_CYCLE = 2'b01;
    push_rd(24'h0F0000);
    wait_req("rd_0000_post_rst");
    ack(32'hA5A55A5A);
    chk("fill_0000", 64'(SVRAM_DATA_IN), 64'hA5A55A5A);

    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
